// File: rtl/rv_pipe_pkg.sv
// Shared types and defaults for the RV32 pipeline front end: fetch entry
// layout, fetch FSM encoding and reset/NOP constants.
package rv_pipe_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR_DEF = 32'h0000_0013;
    localparam logic [PC_W-1:0]    RESET_PC_DEF  = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        KILL = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
        logic [PC_W-1:0]    pc4;
    } fetch_entry_t;

    function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
        return {addr[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory read port: single outstanding word read, in-order
// responses. The fetch stage is the master, the memory the slave.
interface fetch_stage_if;
    import rv_pipe_pkg::*;

    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_rvalid;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_queue.sv
// Two-entry FIFO of fetch entries with flush. Head is read straight from
// the slot array; callers qualify it with count.
module fetch_queue
    import rv_pipe_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t slot [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic         push_ok;
    logic         pop_ok;

    // A push into a full queue is only legal when the head leaves the same cycle.
    assign pop_ok  = pop & (count != 2'd0);
    assign push_ok = push & ((count != 2'd2) | pop_ok);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push_ok) wr_ptr <= ~wr_ptr;
            if (pop_ok)  rd_ptr <= ~rd_ptr;
            count <= count + 2'(push_ok) - 2'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) slot[wr_ptr] <= din;
    end

    assign head = slot[rd_ptr];

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, issues one word read at a time to instruction
// memory, buffers up to two returned words and presents the head to IF/ID.
module fetch_stage
    import rv_pipe_pkg::*;
#(
    parameter logic [PC_W-1:0]    RESET_PC  = RESET_PC_DEF,
    parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    fetch_stage_if.master      imem,
    output logic               fetch_valid,
    output logic [INSTR_W-1:0] instructionOUT,
    output logic [PC_W-1:0]    pcOUT,
    output logic [PC_W-1:0]    pcPlus4OUT
);

    fetch_state_t    state;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] inflight_pc;
    logic            fill;
    logic            consume;
    logic            out_after;
    logic            issue;
    logic [1:0]      q_count;
    logic [2:0]      cnt_next;
    fetch_entry_t    push_entry;
    fetch_entry_t    head;

    assign fetch_valid = (q_count != 2'd0);
    assign fill        = (state == WAIT) & imem.imem_rvalid & ~branch_taken;
    assign consume     = fetch_valid & ~stall;
    assign cnt_next    = {1'b0, q_count} + 3'(fill) - 3'(consume);
    assign out_after   = (state != IDLE) & ~imem.imem_rvalid;

    // Issue only when the word is guaranteed a slot; reset gates the request
    // so the memory sees nothing while the stage is held in reset.
    assign issue = reset & ~branch_taken & (state != KILL) & ~out_after &
                   (cnt_next < 3'd2);

    assign imem.imem_req  = issue;
    assign imem.imem_addr = pc;

    assign push_entry = '{instr: imem.imem_rdata,
                          pc:    inflight_pc,
                          pc4:   inflight_pc + 32'd4};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            pc    <= RESET_PC;
        end else if (branch_taken) begin
            pc    <= word_align(branch_target);
            state <= ((state != IDLE) && !imem.imem_rvalid) ? KILL : IDLE;
        end else if (issue) begin
            pc    <= pc + 32'd4;
            state <= WAIT;
        end else if (imem.imem_rvalid && (state != IDLE)) begin
            state <= IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (issue) inflight_pc <= pc;
    end

    fetch_queue u_queue (
        .clk   (clk),
        .reset (reset),
        .push  (fill),
        .pop   (consume),
        .flush (branch_taken),
        .din   (push_entry),
        .head  (head),
        .count (q_count)
    );

    // Empty queue presents a bubble rather than stale slot contents.
    assign instructionOUT = fetch_valid ? head.instr : NOP_INSTR;
    assign pcOUT          = fetch_valid ? head.pc    : '0;
    assign pcPlus4OUT     = fetch_valid ? head.pc4   : '0;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: variable-latency memory responder plus a program-order
// model of which PCs must be issued and delivered.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        bt = 1'b0;
    logic [31:0] tgt = '0;
    logic        fetch_valid;
    logic [31:0] instructionOUT, pcOUT, pcPlus4OUT;

    fetch_stage_if imem();

    fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .branch_taken   (bt),
        .branch_target  (tgt),
        .imem           (imem),
        .fetch_valid    (fetch_valid),
        .instructionOUT (instructionOUT),
        .pcOUT          (pcOUT),
        .pcPlus4OUT     (pcPlus4OUT)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int lat_min = 1;
    int lat_max = 1;

    logic [31:0] pend_addr[$];
    int          pend_rdy[$];
    logic        stray;
    logic [31:0] exp_pc, exp_issue, held_pc;
    logic        prev_bt, prev_hold;
    logic [31:0] iss_log[$], con_log[$], con4_log[$];
    logic        s_req, s_fv, s_rvalid;
    logic [31:0] s_addr, s_instr, s_pc, s_pc4;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hBAD0_BAD0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic model_init(input logic [31:0] start);
        pend_addr.delete();
        pend_rdy.delete();
        exp_pc = start;
        exp_issue = start;
        prev_bt = 1'b0;
        prev_hold = 1'b0;
        held_pc = '0;
    endtask

    task automatic clear_logs();
        iss_log.delete();
        con_log.delete();
        con4_log.delete();
    endtask

    // One clock cycle: drive, sample at negedge, check, advance the model.
    task automatic cycle(input logic st, input logic b, input logic [31:0] t);
        logic        rv, stray_now;
        logic [31:0] rd;
        int          done;
        stall = st; bt = b; tgt = t;
        stray_now = stray;
        rv = 1'b0;
        rd = $urandom;
        if (stray_now) begin
            rv = 1'b1;
        end else if (pend_addr.size() != 0 && cyc >= pend_rdy[0]) begin
            rv = 1'b1;
            rd = mem_word(pend_addr[0]);
        end
        imem.imem_rvalid = rv;
        imem.imem_rdata  = rd;
        @(negedge clk);
        s_req = imem.imem_req; s_addr = imem.imem_addr; s_rvalid = rv;
        s_fv = fetch_valid; s_instr = instructionOUT; s_pc = pcOUT; s_pc4 = pcPlus4OUT;

        if (prev_bt) chk("flush_empty", 32'(s_fv), 32'd0);
        if (prev_hold) begin
            chk("stall_valid", 32'(s_fv), 32'd1);
            chk("stall_pc", s_pc, held_pc);
        end
        if (s_fv) begin
            chk("head_pc", s_pc, exp_pc);
            chk("head_pc4", s_pc4, exp_pc + 32'd4);
            chk("head_instr", s_instr, mem_word(exp_pc));
        end else begin
            chk("empty_instr", s_instr, NOP);
            chk("empty_pc", s_pc, 32'd0);
            chk("empty_pc4", s_pc4, 32'd0);
        end
        if (b) chk("req_in_redirect", 32'(s_req), 32'd0);
        done = (rv && !stray_now) ? 1 : 0;
        if (s_req) begin
            chk("issue_addr", s_addr, exp_issue);
            chk("one_outstanding", 32'(pend_addr.size() - done), 32'd0);
            iss_log.push_back(s_addr);
        end

        if (done == 1) begin
            void'(pend_addr.pop_front());
            void'(pend_rdy.pop_front());
        end
        stray = 1'b0;
        if (s_req) begin
            pend_addr.push_back(s_addr);
            pend_rdy.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
            exp_issue = exp_issue + 32'd4;
        end
        if (s_fv && !st && !b) begin
            con_log.push_back(s_pc);
            con4_log.push_back(s_pc4);
            exp_pc = exp_pc + 32'd4;
        end
        prev_hold = s_fv && st && !b;
        held_pc = s_pc;
        prev_bt = b;
        if (b) begin
            exp_pc = {t[31:2], 2'b00};
            exp_issue = {t[31:2], 2'b00};
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        logic        found;
        logic [31:0] t;
        stray = 1'b0;
        imem.imem_rvalid = 1'b0;
        imem.imem_rdata = '0;
        model_init(32'h0);

        // Reset asserted: outputs show a bubble and nothing is requested.
        #1 reset = 1'b0;
        #2;
        chk("rst_fv", 32'(fetch_valid), 32'd0);
        chk("rst_instr", instructionOUT, NOP);
        chk("rst_pc", pcOUT, 32'd0);
        chk("rst_pc4", pcPlus4OUT, 32'd0);
        chk("rst_req", 32'(imem.imem_req), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;

        // Back-to-back stream with 1-cycle memory.
        lat_min = 1; lat_max = 1;
        clear_logs();
        cycle(0, 0, 0); chk("t1_fv_c0", 32'(s_fv), 32'd0);
        cycle(0, 0, 0); chk("t1_fv_c1", 32'(s_fv), 32'd0);
        cycle(0, 0, 0); chk("t1_fv_c2", 32'(s_fv), 32'd1);
        cycle(0, 0, 0);
        chk("t1_iss0", at(iss_log, 0), 32'h0);
        chk("t1_iss1", at(iss_log, 1), 32'h4);
        chk("t1_iss2", at(iss_log, 2), 32'h8);
        chk("t1_con0", at(con_log, 0), 32'h0);
        chk("t1_con1", at(con_log, 1), 32'h4);
        chk("t1_pc4_1", at(con4_log, 1), 32'h8);

        // Stall mid-stream: requests stop once the queue is committed.
        for (int i = 0; i < 3; i++) cycle(0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cycle(1, 0, 0);
            if (i >= 1) chk("t2_stall_req", 32'(s_req), 32'd0);
        end
        clear_logs();
        for (int i = 0; i < 6; i++) cycle(0, 0, 0);
        chk("t2_resume_n", 32'(con_log.size() >= 4), 32'd1);
        chk("t2_resume_step", at(con_log, 1) - at(con_log, 0), 32'd4);

        // Redirect while a 3-cycle read is outstanding: stale word discarded.
        lat_min = 3; lat_max = 3;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle(0, 0, 0);
            found = s_req;
        end
        chk("t3_req_seen", 32'(found), 32'd1);
        cycle(0, 1, 32'h100);
        clear_logs();
        cycle(0, 0, 0); chk("t3_kill_no_req", 32'(s_req), 32'd0);
        for (int i = 0; i < 12; i++) cycle(0, 0, 0);
        chk("t3_first_iss", at(iss_log, 0), 32'h100);
        chk("t3_first_con", at(con_log, 0), 32'h100);

        // Redirect coinciding with the response: no kill wait.
        lat_min = 1; lat_max = 1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle(0, 0, 0);
            found = s_req;
        end
        chk("t4_req_seen", 32'(found), 32'd1);
        cycle(0, 1, 32'h40);
        cycle(0, 0, 0);
        chk("t4_issue", 32'(s_req), 32'd1);
        chk("t4_addr", s_addr, 32'h40);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0);

        // Asynchronous reset mid-WAIT with a valid head.
        lat_min = 3; lat_max = 3;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle(0, 0, 0);
            found = s_req && s_rvalid;
        end
        chk("t5_setup", 32'(found), 32'd1);
        stall = 1'b1;
        imem.imem_rvalid = 1'b0;
        #1 chk("t5_pre_valid", 32'(fetch_valid), 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("t5_fv", 32'(fetch_valid), 32'd0);
        chk("t5_instr", instructionOUT, NOP);
        chk("t5_pc", pcOUT, 32'd0);
        chk("t5_pc4", pcPlus4OUT, 32'd0);
        chk("t5_req", 32'(imem.imem_req), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        model_init(32'h0);
        clear_logs();
        stray = 1'b1;
        cycle(0, 0, 0);
        chk("t5_req_after", 32'(s_req), 32'd1);
        chk("t5_addr_after", s_addr, 32'h0);
        for (int i = 0; i < 10; i++) cycle(0, 0, 0);
        chk("t5_first_con", at(con_log, 0), 32'h0);

        // PC wrap at the top of the address space.
        lat_min = 1; lat_max = 1;
        cycle(0, 1, 32'hFFFF_FFF8);
        clear_logs();
        for (int i = 0; i < 8; i++) cycle(0, 0, 0);
        chk("t6_iss0", at(iss_log, 0), 32'hFFFF_FFF8);
        chk("t6_iss1", at(iss_log, 1), 32'hFFFF_FFFC);
        chk("t6_iss2", at(iss_log, 2), 32'h0);
        chk("t6_con1", at(con_log, 1), 32'hFFFF_FFFC);
        chk("t6_pc4_1", at(con4_log, 1), 32'h0);
        chk("t6_con2", at(con_log, 2), 32'h0);

        // Random latency, stalls and redirects (including unaligned targets).
        lat_min = 1; lat_max = 4;
        clear_logs();
        for (int i = 0; i < 800; i++) begin
            t = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0)))
                                            : $urandom;
            cycle($urandom_range(9, 0) < 3, $urandom_range(39, 0) == 0, t);
        end
        chk("rand_progress", 32'(con_log.size() > 50), 32'd1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
